// File: rtl/fifo_event_deframer.sv
// fifo_event_deframer
//   Read-side deframer for the 16-bit tube-event stream held in the dual-clock
//   event FIFO. Pops words under its own flow control, parses frames of
//   WORDS_PER_EVENT tube words plus a terminator, checks each tag against the
//   fixed tube order, and emits one decoded hit per tube word on a
//   valid/ready handshake. It also reports per-frame status and running counters.
//
//   Build option: define FIFO_DEFRAME_ZERO_SUPPRESS_EN to drop hits whose
//   time field is zero. These words are still tag-checked and counted.
//
// Ports
//   RD_CLK       FIFO read clock. All logic runs on its rising edge.
//   CLR_N        synchronous active-low clear
//   FIFO_DOUT    FIFO read data: [15:8] hit time, [7:0] tube tag
//   FIFO_EMPTY   FIFO empty flag
//   FIFO_VALID   FIFO_DOUT valid, one cycle after an accepted FIFO_RD_EN
//   FIFO_RD_EN   pop request (registered)
//   HIT_VALID    decoded hit available
//   HIT_READY    downstream accepts the hit
//   HIT_CHAMBER  0 = chamber 3, 1 = chamber 4
//   HIT_LAYER    0 = layer A, 1 = layer B
//   HIT_INDEX    tube index 0..7
//   HIT_TIME     time field of the tube word
//   EVT_DONE     one-cycle pulse when a frame ends (terminator or abort)
//   EVT_ERR      status of the last finished frame (1 = bad)
//   EVT_COUNT    good frames, wraps
//   ERR_COUNT    bad frames, saturates at 255
module fifo_event_deframer #(
  parameter int unsigned WORDS_PER_EVENT = 32,
  parameter logic [15:0] TERM_WORD       = 16'hFFFF,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             RD_CLK,
  input  logic             CLR_N,
  input  logic [15:0]      FIFO_DOUT,
  input  logic             FIFO_EMPTY,
  input  logic             FIFO_VALID,
  output logic             FIFO_RD_EN,
  output logic             HIT_VALID,
  input  logic             HIT_READY,
  output logic             HIT_CHAMBER,
  output logic             HIT_LAYER,
  output logic [2:0]       HIT_INDEX,
  output logic [7:0]       HIT_TIME,
  output logic             EVT_DONE,
  output logic             EVT_ERR,
  output logic [CNT_W-1:0] EVT_COUNT,
  output logic [7:0]       ERR_COUNT
);

  localparam int unsigned K_W = $clog2(WORDS_PER_EVENT + 1);

  typedef enum logic [1:0] {S_HUNT, S_DATA, S_TERM, S_DROP} state_t;

  // Tube order: chamber selects the upper tag bits, and the index bits are
  // stored reversed in the tag.
  function automatic logic [7:0] exp_tag(input logic [4:0] k);
    return {(k[4] ? 3'b001 : 3'b110), 1'b0, k[3], k[0], k[1], k[2]};
  endfunction

  // Input buffer and read tracking
  logic [15:0]      r_buf [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;
  logic             r_infl;
  logic             r_rd_en;

  // FSM and outputs
  state_t           r_state;
  state_t           w_state_n;
  logic [K_W-1:0]   r_k;
  logic [K_W-1:0]   w_k_n;
  logic [K_W-1:0]   w_k_inc;
  logic             r_hit_valid;
  logic             r_hit_chamber;
  logic             r_hit_layer;
  logic [2:0]       r_hit_index;
  logic [7:0]       r_hit_time;
  logic             r_evt_done;
  logic             r_evt_err;
  logic [CNT_W-1:0] r_evt_count;
  logic [7:0]       r_err_count;

  logic             w_in_valid;
  logic             w_from_buf;
  logic             w_head_valid;
  logic [15:0]      w_head;
  logic             w_is_term;
  logic             w_tag_ok;
  logic             w_out_free;
  logic             w_suppress;
  logic             w_good;
  logic             w_consume;
  logic             w_hit_load;
  logic             w_done;
  logic             w_err;
  logic             w_buf_wr;
  logic             w_buf_rd;
  logic [1:0]       w_occ_n;
  logic             w_infl_n;
  logic [1:0]       w_fill;

  // Data returned for a read issued before a clear finds r_infl low and is dropped.
  assign w_in_valid   = FIFO_VALID && r_infl;
  assign w_from_buf   = (r_occ != 2'd0);
  assign w_head_valid = w_from_buf || w_in_valid;
  // When the buffer is empty the arriving word is consumed directly, so
  // FIFO_VALID reaches HIT_VALID in one cycle.
  assign w_head       = w_from_buf ? r_buf[r_rptr] : FIFO_DOUT;
  assign w_is_term    = (w_head == TERM_WORD);
  assign w_tag_ok     = (w_head[7:0] == exp_tag(r_k[4:0]));
  assign w_out_free   = !r_hit_valid || HIT_READY;
  assign w_k_inc      = r_k + K_W'(1);

`ifdef FIFO_DEFRAME_ZERO_SUPPRESS_EN
  assign w_suppress = (w_head[15:8] == 8'd0);
`else
  assign w_suppress = 1'b0;
`endif

  // The hit register acts as a third slot after the two-entry buffer. The
  // buffer can then stay at or below one word while the pop loop runs at
  // full rate, and a long downstream stall still cannot overflow it.
  assign w_buf_wr = w_in_valid && !(!w_from_buf && w_consume);
  assign w_buf_rd = w_from_buf && w_consume;
  assign w_occ_n  = r_occ + {1'b0, w_buf_wr} - {1'b0, w_buf_rd};
  assign w_infl_n = r_rd_en && !FIFO_EMPTY;
  assign w_fill   = w_occ_n + {1'b0, w_infl_n};

  always_ff @(posedge RD_CLK) begin
    if (!CLR_N) begin
      r_buf   <= '{default: '0};
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_occ   <= '0;
      r_infl  <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      if (w_buf_wr) begin
        r_buf[r_wptr] <= FIFO_DOUT;
        r_wptr        <= ~r_wptr;
      end
      if (w_buf_rd) begin
        r_rptr <= ~r_rptr;
      end
      r_occ   <= w_occ_n;
      r_infl  <= w_infl_n;
      r_rd_en <= !FIFO_EMPTY && (w_fill < 2'd2);
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_k_n      = r_k;
    w_consume  = 1'b0;
    w_hit_load = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_good     = 1'b0;
    if (w_head_valid) begin
      unique case (r_state)
        S_HUNT: begin
          // r_k is always zero here, so w_tag_ok compares against word 0.
          if (!w_is_term && w_tag_ok) begin
            w_good = 1'b1;
          end else begin
            w_consume = 1'b1;
          end
        end
        S_DATA: begin
          if (w_is_term) begin
            w_consume = 1'b1;
            w_done    = 1'b1;
            w_err     = 1'b1;
            w_k_n     = '0;
            w_state_n = S_HUNT;
          end else if (!w_tag_ok) begin
            w_consume = 1'b1;
            w_done    = 1'b1;
            w_err     = 1'b1;
            w_k_n     = '0;
            w_state_n = S_DROP;
          end else begin
            w_good = 1'b1;
          end
        end
        S_TERM: begin
          w_consume = 1'b1;
          w_done    = 1'b1;
          w_k_n     = '0;
          if (w_is_term) begin
            w_state_n = S_HUNT;
          end else begin
            w_err     = 1'b1;
            w_state_n = S_DROP;
          end
        end
        S_DROP: begin
          w_consume = 1'b1;
          if (w_is_term) begin
            w_state_n = S_HUNT;
          end
        end
        default: begin
          w_state_n = S_HUNT;
        end
      endcase
      // A suppressed word needs no output slot, so it never waits for one.
      if (w_good && (w_suppress || w_out_free)) begin
        w_consume  = 1'b1;
        w_hit_load = !w_suppress;
        w_k_n      = w_k_inc;
        w_state_n  = (w_k_inc == K_W'(WORDS_PER_EVENT)) ? S_TERM : S_DATA;
      end
    end
  end

  always_ff @(posedge RD_CLK) begin
    if (!CLR_N) begin
      r_state       <= S_HUNT;
      r_k           <= '0;
      r_hit_valid   <= 1'b0;
      r_hit_chamber <= 1'b0;
      r_hit_layer   <= 1'b0;
      r_hit_index   <= '0;
      r_hit_time    <= '0;
      r_evt_done    <= 1'b0;
      r_evt_err     <= 1'b0;
      r_evt_count   <= '0;
      r_err_count   <= '0;
    end else begin
      r_state <= w_state_n;
      r_k     <= w_k_n;
      if (w_hit_load) begin
        r_hit_valid   <= 1'b1;
        r_hit_chamber <= r_k[4];
        r_hit_layer   <= r_k[3];
        r_hit_index   <= r_k[2:0];
        r_hit_time    <= w_head[15:8];
      end else if (HIT_READY) begin
        r_hit_valid <= 1'b0;
      end
      r_evt_done <= w_done;
      if (w_done) begin
        r_evt_err <= w_err;
      end
      if (w_done && !w_err) begin
        r_evt_count <= r_evt_count + CNT_W'(1);
      end
      if (w_done && w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign FIFO_RD_EN  = r_rd_en;
  assign HIT_VALID   = r_hit_valid;
  assign HIT_CHAMBER = r_hit_chamber;
  assign HIT_LAYER   = r_hit_layer;
  assign HIT_INDEX   = r_hit_index;
  assign HIT_TIME    = r_hit_time;
  assign EVT_DONE    = r_evt_done;
  assign EVT_ERR     = r_evt_err;
  assign EVT_COUNT   = r_evt_count;
  assign ERR_COUNT   = r_err_count;

endmodule

// File: tb/tb_fifo_event_deframer.sv
module tb_fifo_event_deframer;

  logic        RD_CLK;
  logic        CLR_N;
  logic [15:0] FIFO_DOUT;
  logic        FIFO_EMPTY;
  logic        FIFO_VALID;
  logic        FIFO_RD_EN;
  logic        HIT_VALID;
  logic        HIT_READY;
  logic        HIT_CHAMBER;
  logic        HIT_LAYER;
  logic [2:0]  HIT_INDEX;
  logic [7:0]  HIT_TIME;
  logic        EVT_DONE;
  logic        EVT_ERR;
  logic [15:0] EVT_COUNT;
  logic [7:0]  ERR_COUNT;

  fifo_event_deframer #(
    .WORDS_PER_EVENT(32),
    .TERM_WORD(16'hFFFF),
    .CNT_W(16)
  ) dut (
    .RD_CLK(RD_CLK),
    .CLR_N(CLR_N),
    .FIFO_DOUT(FIFO_DOUT),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_VALID(FIFO_VALID),
    .FIFO_RD_EN(FIFO_RD_EN),
    .HIT_VALID(HIT_VALID),
    .HIT_READY(HIT_READY),
    .HIT_CHAMBER(HIT_CHAMBER),
    .HIT_LAYER(HIT_LAYER),
    .HIT_INDEX(HIT_INDEX),
    .HIT_TIME(HIT_TIME),
    .EVT_DONE(EVT_DONE),
    .EVT_ERR(EVT_ERR),
    .EVT_COUNT(EVT_COUNT),
    .ERR_COUNT(ERR_COUNT)
  );

  initial begin
    RD_CLK = 1'b0;
    forever #5 RD_CLK = ~RD_CLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read side of the event FIFO: data appears one cycle after an accepted pop.
  logic [15:0] fq[$];
  logic        pend = 1'b0;
  int          npops = 0;

  initial begin
    FIFO_DOUT  = '0;
    FIFO_VALID = 1'b0;
    FIFO_EMPTY = 1'b1;
  end

  always @(negedge RD_CLK) begin
    if (pend) begin
      FIFO_DOUT  = fq.pop_front();
      FIFO_VALID = 1'b1;
      npops++;
    end else begin
      FIFO_VALID = 1'b0;
    end
    FIFO_EMPTY = (fq.size() == 0);
    pend = FIFO_RD_EN && !FIFO_EMPTY;
  end

  // Hit sink: 0 = always ready, 1 = toggles each cycle, 2 = held low.
  int          rmode = 0;
  logic [12:0] hq[$];
  logic        eq[$];
  logic        stall_pend = 1'b0;
  logic [12:0] stall_hit = '0;
  logic [12:0] w_hit;
  assign w_hit = {HIT_CHAMBER, HIT_LAYER, HIT_INDEX, HIT_TIME};

  initial HIT_READY = 1'b0;

  always @(negedge RD_CLK) begin
    if (stall_pend) begin
      chk("stall_valid", {31'd0, HIT_VALID}, 32'd1);
      chk("stall_hold", {19'd0, w_hit}, {19'd0, stall_hit});
    end
    case (rmode)
      0:       HIT_READY = 1'b1;
      1:       HIT_READY = ~HIT_READY;
      default: HIT_READY = 1'b0;
    endcase
    if (HIT_VALID && HIT_READY) hq.push_back(w_hit);
    stall_pend = HIT_VALID && !HIT_READY && CLR_N;
    stall_hit  = w_hit;
    if (EVT_DONE) eq.push_back(EVT_ERR);
  end

  function automatic logic [7:0] tag_of(input int k);
    logic [4:0] kb;
    kb = k[4:0];
    return {(kb[4] ? 3'b001 : 3'b110), 1'b0, kb[3], kb[0], kb[1], kb[2]};
  endfunction

  function automatic logic [7:0] time_of(input int k, input int zmode);
    logic [7:0] t;
    t = 8'(k + 1);
    if (zmode != 0 && (k % 2) == 0) t = 8'd0;
    return t;
  endfunction

  task automatic push_frame(input int n, input int zmode);
    for (int k = 0; k < n; k++) fq.push_back({time_of(k, zmode), tag_of(k)});
  endtask

  task automatic push_term();
    fq.push_back(16'hFFFF);
  endtask

  task automatic start();
    hq.delete();
    eq.delete();
  endtask

  task automatic wait_evt(input int n, input string tag);
    int cyc;
    cyc = 0;
    while ((eq.size() < n || fq.size() != 0) && cyc < 600) begin
      @(negedge RD_CLK);
      cyc++;
    end
    chk({tag, "_evt_seen"}, {31'd0, (eq.size() >= n)}, 32'd1);
    repeat (8) @(negedge RD_CLK);
  endtask

  // Hits k = first, first+step, ... each decode to {k[4], k[3], k[2:0], time}.
  task automatic check_hits(input string tag, input int n, input int first, input int step,
                            input int zmode);
    int k;
    logic [4:0] kb;
    chk({tag, "_nhits"}, hq.size(), n);
    for (int i = 0; i < n; i++) begin
      k  = first + i * step;
      kb = k[4:0];
      chk({tag, "_hit"}, {19'd0, hq[i]}, {19'd0, kb[4], kb[3], kb[2:0], time_of(k, zmode)});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_hit_valid"}, {31'd0, HIT_VALID}, 32'd0);
    chk({tag, "_evt_done"}, {31'd0, EVT_DONE}, 32'd0);
    chk({tag, "_evt_err"}, {31'd0, EVT_ERR}, 32'd0);
    chk({tag, "_evt_count"}, {16'd0, EVT_COUNT}, 32'd0);
    chk({tag, "_err_count"}, {24'd0, ERR_COUNT}, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, FIFO_RD_EN}, 32'd0);
    chk({tag, "_hit_fields"}, {19'd0, w_hit}, 32'd0);
  endtask

  initial begin
    int base;
    int cyc;
    CLR_N = 1'b0;
    repeat (3) @(negedge RD_CLK);
    check_idle_outputs("reset");
    CLR_N = 1'b1;
    @(negedge RD_CLK);

    // Clean frame, always ready
    start();
    push_frame(32, 0);
    push_term();
    wait_evt(1, "clean");
    check_hits("clean", 32, 0, 1, 0);
    chk("clean_first", {19'd0, hq[0]}, {19'd0, 13'h0001});
    chk("clean_nevt", eq.size(), 1);
    chk("clean_err", {31'd0, eq[0]}, 32'd0);
    chk("clean_evt_count", {16'd0, EVT_COUNT}, 32'd1);
    chk("clean_err_count", {24'd0, ERR_COUNT}, 32'd0);

    // Same frame, ready toggling
    start();
    rmode = 1;
    push_frame(32, 0);
    push_term();
    wait_evt(1, "bp");
    check_hits("bp", 32, 0, 1, 0);
    chk("bp_err", {31'd0, eq[0]}, 32'd0);
    chk("bp_evt_count", {16'd0, EVT_COUNT}, 32'd2);

    // Ready held low: hit register plus two buffer words, then no more pops
    start();
    rmode = 2;
    base = npops;
    push_frame(32, 0);
    push_term();
    repeat (20) @(negedge RD_CLK);
    chk("stall_pops", npops - base, 3);
    chk("stall_rd_en", {31'd0, FIFO_RD_EN}, 32'd0);
    chk("stall_hit_valid", {31'd0, HIT_VALID}, 32'd1);
    chk("stall_hit0", {19'd0, w_hit}, {19'd0, 13'h0001});
    rmode = 0;
    wait_evt(1, "stall");
    check_hits("stall", 32, 0, 1, 0);
    chk("stall_evt_count", {16'd0, EVT_COUNT}, 32'd3);

    // Short frame, then a good frame
    start();
    push_frame(20, 0);
    push_term();
    wait_evt(1, "short");
    check_hits("short", 20, 0, 1, 0);
    chk("short_err", {31'd0, eq[0]}, 32'd1);
    chk("short_err_count", {24'd0, ERR_COUNT}, 32'd1);
    start();
    push_frame(32, 0);
    push_term();
    wait_evt(1, "after_short");
    check_hits("after_short", 32, 0, 1, 0);
    chk("after_short_evt_count", {16'd0, EVT_COUNT}, 32'd4);

    // Word 5 carries tag C0 (expected C5); the rest of the frame is dropped
    start();
    push_frame(5, 0);
    fq.push_back({8'd6, 8'hC0});
    for (int k = 6; k < 32; k++) fq.push_back({time_of(k, 0), tag_of(k)});
    push_term();
    wait_evt(1, "badtag");
    check_hits("badtag", 5, 0, 1, 0);
    chk("badtag_nevt", eq.size(), 1);
    chk("badtag_err", {31'd0, eq[0]}, 32'd1);
    chk("badtag_err_count", {24'd0, ERR_COUNT}, 32'd2);
    start();
    push_frame(32, 0);
    push_term();
    wait_evt(1, "after_bad");
    check_hits("after_bad", 32, 0, 1, 0);
    chk("after_bad_evt_count", {16'd0, EVT_COUNT}, 32'd5);

    // Leading filler words are ignored
    start();
    repeat (3) push_term();
    push_frame(32, 0);
    push_term();
    wait_evt(1, "filler");
    check_hits("filler", 32, 0, 1, 0);
    chk("filler_nevt", eq.size(), 1);
    chk("filler_evt_count", {16'd0, EVT_COUNT}, 32'd6);

    // Long frame: extra word where the terminator should be
    start();
    push_frame(32, 0);
    fq.push_back({8'd5, 8'hC0});
    push_term();
    wait_evt(1, "long");
    check_hits("long", 32, 0, 1, 0);
    chk("long_nevt", eq.size(), 1);
    chk("long_err", {31'd0, eq[0]}, 32'd1);
    chk("long_err_count", {24'd0, ERR_COUNT}, 32'd3);
    chk("long_evt_count", {16'd0, EVT_COUNT}, 32'd6);

    // Even words have time 0
    start();
    push_frame(32, 1);
    push_term();
    wait_evt(1, "zero");
`ifdef FIFO_DEFRAME_ZERO_SUPPRESS_EN
    check_hits("zero", 16, 1, 2, 1);
`else
    check_hits("zero", 32, 0, 1, 1);
`endif
    chk("zero_err", {31'd0, eq[0]}, 32'd0);
    chk("zero_evt_count", {16'd0, EVT_COUNT}, 32'd7);

    // Clear in the middle of a frame
    start();
    push_frame(32, 0);
    push_term();
    cyc = 0;
    while (hq.size() < 10 && cyc < 200) begin
      @(negedge RD_CLK);
      cyc++;
    end
    chk("midrst_reached", {31'd0, (hq.size() >= 10)}, 32'd1);
    CLR_N = 1'b0;
    @(negedge RD_CLK);
    check_idle_outputs("midrst");
    start();
    CLR_N = 1'b1;
    cyc = 0;
    while (fq.size() != 0 && cyc < 200) begin
      @(negedge RD_CLK);
      cyc++;
    end
    repeat (10) @(negedge RD_CLK);
    chk("midrst_drained", fq.size(), 0);
    chk("midrst_nhits", hq.size(), 0);
    chk("midrst_nevt", eq.size(), 0);
    chk("midrst_evt_count", {16'd0, EVT_COUNT}, 32'd0);
    chk("midrst_err_count", {24'd0, ERR_COUNT}, 32'd0);
    start();
    push_frame(32, 0);
    push_term();
    wait_evt(1, "after_rst");
    check_hits("after_rst", 32, 0, 1, 0);
    chk("after_rst_err", {31'd0, eq[0]}, 32'd0);
    chk("after_rst_evt_count", {16'd0, EVT_COUNT}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
